// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: Basys3 4-digit seven-segment scan controller.
// Optional leading-zero blanking when SEG7_LZB_EN is defined.
module seg7_scan_ctrl #(
  parameter int DIGIT_CYC = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic [3:0]  digit_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic [1:0]  digit_idx,
  output logic        frame_tick
);

  localparam int CM0 = (DIGIT_CYC > BLANK_CYC) ? DIGIT_CYC : BLANK_CYC;
  localparam int CMAX = (CM0 > 2) ? CM0 : 2;
  localparam int CW = $clog2(CMAX);
  localparam logic [CW-1:0] DTERM = CW'(DIGIT_CYC - 1);
  localparam logic [CW-1:0] BTERM =
    CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  typedef enum logic {S_BLANK, S_SHOW} state_t;

  state_t        state, nstate;
  logic [CW-1:0] cnt, ncnt;
  logic [1:0]    idx, nidx;
  logic          started, nstarted;
  logic          enter, load;

  logic [15:0]   snap_val, sval;
  logic [3:0]    snap_dp, sdp;
  logic [3:0]    snap_en, sen;
  logic [3:0]    zb, ven;
  logic [3:0]    nib;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          dpn_d;

  function automatic logic [6:0] hexdec(input logic [3:0] h);
    logic [6:0] s;
    s = 7'h7F;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Next-state, counter and digit index sequencing.
  always_comb begin
    nstate   = state;
    ncnt     = cnt + 1'b1;
    nidx     = idx;
    nstarted = started;
    enter    = 1'b0;
    unique case (state)
      S_BLANK: begin
        if (cnt == BTERM) begin
          nstate   = S_SHOW;
          ncnt     = '0;
          enter    = 1'b1;
          nstarted = 1'b1;
          nidx     = started ? idx + 2'd1 : idx;
        end
      end
      S_SHOW: begin
        if (cnt == DTERM) begin
          ncnt = '0;
          if (BLANK_CYC == 0) begin
            nidx  = idx + 2'd1;
            enter = 1'b1;
          end else begin
            nstate = S_BLANK;
          end
        end
      end
      default: ;
    endcase
    load = enter && (nidx == 2'd0);
  end

  // Output decode for the cycle being entered; a new frame uses live inputs.
  always_comb begin
    sval  = load ? value : snap_val;
    sdp   = load ? dp : snap_dp;
    sen   = load ? digit_en : snap_en;
`ifdef SEG7_LZB_EN
    zb[0] = 1'b0;
    zb[1] = (sval[15:4] == 12'h000) && !sdp[1];
    zb[2] = (sval[15:8] == 8'h00) && !sdp[2];
    zb[3] = (sval[15:12] == 4'h0) && !sdp[3];
`else
    zb    = 4'h0;
`endif
    ven   = sen & ~zb;
    nib   = 4'(sval >> {nidx, 2'b00});
    an_d  = 4'hF;
    seg_d = 7'h7F;
    dpn_d = 1'b1;
    if (nstate == S_SHOW && ven[nidx]) begin
      an_d  = ~(4'b0001 << nidx);
      seg_d = hexdec(nib);
      dpn_d = ~sdp[nidx];
    end
  end

  // State, counter and index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_BLANK;
      cnt     <= '0;
      idx     <= 2'd0;
      started <= 1'b0;
    end else begin
      state   <= nstate;
      cnt     <= ncnt;
      idx     <= nidx;
      started <= nstarted;
    end
  end

  // Frame snapshot so a whole frame shows one consistent value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_val <= 16'h0000;
      snap_dp  <= 4'h0;
      snap_en  <= 4'h0;
    end else if (load) begin
      snap_val <= value;
      snap_dp  <= dp;
      snap_en  <= digit_en;
    end
  end

  // Registered pin drivers, updated on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= 4'hF;
      seg        <= 7'h7F;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_d;
      seg        <= seg_d;
      dp_n       <= dpn_d;
      frame_tick <= load;
    end
  end

  assign digit_idx = idx;

endmodule
